// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: packs a little-endian byte stream into 16-bit
// words written from address 0; define CHECKSUM_EN to require a trailing zero-sum check byte.
module imem_loader #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [15:0]       imem_wdata,
   output logic              cpu_rst_n,
   output logic              done,
   output logic              error,
   output logic [ADDR_W:0]   words_loaded
);

   localparam logic [16:0] DEPTH = 17'd1 << ADDR_W;

   typedef enum logic [2:0] {
      IDLE, LEN_LO, LEN_HI, DATA_LO, DATA_HI, CHK, DONE, ERR
   } state_t;

   state_t            state_q, state_d, end_st;
   logic [15:0]       len_q, len_d;
   logic [7:0]        lo_q, lo_d;
   logic [7:0]        sum_q, sum_d;
   logic [ADDR_W:0]   wl_q, wl_d, wl_inc;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [15:0]       wdata_q, wdata_d;
   logic              rdy_q, rdy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              cpu_q, cpu_d;
   logic              accept;
   logic [16:0]       len_full;

   // Handshake: a byte transfers on each rising edge where in_valid && in_ready; the
   // producer holds in_data stable while in_valid is high and not yet accepted.
   assign accept   = in_valid && rdy_q;
   assign wl_inc   = wl_q + 1'b1;
   assign len_full = {1'b0, in_data, len_q[7:0]};

`ifdef CHECKSUM_EN
   assign end_st = CHK;
`else
   assign end_st = DONE;
`endif

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      lo_d    = lo_q;
      sum_d   = sum_q;
      wl_d    = wl_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      if (accept) sum_d = sum_q + in_data;
      case (state_q)
         IDLE, DONE, ERR: begin
            if (start) begin
               state_d = LEN_LO;
               wl_d    = '0;
               addr_d  = '0;
               sum_d   = '0;
            end
         end
         LEN_LO: begin
            if (accept) begin
               len_d   = {8'd0, in_data};
               state_d = LEN_HI;
            end
         end
         LEN_HI: begin
            if (accept) begin
               len_d[15:8] = in_data;
               if (len_full > DEPTH)      state_d = ERR;
               else if (len_full == '0)   state_d = end_st;
               else                       state_d = DATA_LO;
            end
         end
         DATA_LO: begin
            if (accept) begin
               lo_d    = in_data;
               state_d = DATA_HI;
            end
         end
         DATA_HI: begin
            if (accept) begin
               we_d    = 1'b1;
               addr_d  = wl_q[ADDR_W-1:0];
               wdata_d = {in_data, lo_q};
               wl_d    = wl_inc;
               state_d = (16'(wl_inc) == len_q) ? end_st : DATA_LO;
            end
         end
`ifdef CHECKSUM_EN
         CHK: begin
            // sum_d already includes the check byte itself
            if (accept) state_d = (sum_d == 8'd0) ? DONE : ERR;
         end
`endif
         default: state_d = IDLE;
      endcase
      rdy_d  = (state_d == LEN_LO) || (state_d == LEN_HI) || (state_d == DATA_LO) ||
               (state_d == DATA_HI) || (state_d == CHK);
      done_d = (state_d == DONE);
      cpu_d  = (state_d == DONE);
      err_d  = (state_d == ERR);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         len_q   <= '0;
         lo_q    <= '0;
         sum_q   <= '0;
         wl_q    <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdy_q   <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         cpu_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         lo_q    <= lo_d;
         sum_q   <= sum_d;
         wl_q    <= wl_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdy_q   <= rdy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         cpu_q   <= cpu_d;
      end
   end

   assign in_ready     = rdy_q;
   assign imem_we      = we_q;
   assign imem_addr    = addr_q;
   assign imem_wdata   = wdata_q;
   assign cpu_rst_n    = cpu_q;
   assign done         = done_q;
   assign error        = err_q;
   assign words_loaded = wl_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed and random byte streams against a stream-level model;
// memory writes are scoreboarded from a queue of expected {addr, data} entries.
module tb_imem_loader;

   localparam int ADDR_W = 8;
   localparam int DEPTH  = 256;

   typedef logic [7:0] bq_t[$];

   logic              clk;
   logic              rst_n;
   logic              start;
   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [15:0]       imem_wdata;
   logic              cpu_rst_n;
   logic              done;
   logic              error;
   logic [ADDR_W:0]   words_loaded;

   imem_loader #(.ADDR_W(ADDR_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .imem_we      (imem_we),
      .imem_addr    (imem_addr),
      .imem_wdata   (imem_wdata),
      .cpu_rst_n    (cpu_rst_n),
      .done         (done),
      .error        (error),
      .words_loaded (words_loaded)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   logic [23:0] exp_q[$];

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // scoreboard: every write strobe must match the head of exp_q
   always @(negedge clk) begin
      if (imem_we) begin
         if (exp_q.size() == 0) check_val("unexpected_write", {8'd0, imem_addr, imem_wdata}, 32'hFFFF_FFFF);
         else check_val("write", {8'd0, imem_addr, imem_wdata}, {8'd0, exp_q.pop_front()});
      end
      if (done && error) check_val("done_error_exclusive", 32'd1, 32'd0);
   end

   // append the check byte in checksum builds; corrupt flips its LSB
   function automatic bq_t finalize(bq_t s, bit corrupt);
      bq_t r;
      logic [7:0] sum;
      r = s;
      sum = 8'd0;
      foreach (s[i]) sum = sum + s[i];
`ifdef CHECKSUM_EN
      r.push_back((8'd0 - sum) ^ {7'd0, corrupt});
`else
      if (corrupt && sum == 8'd0) r = s;
`endif
      return r;
   endfunction

   // reference model: derive outcome of a complete stream and queue its writes
   task automatic model_load(input bq_t s, output bit e_done, output bit e_err, output int e_words);
      int n;
      logic [7:0] sum;
      n = int'({s[1], s[0]});
      e_done = 1'b0;
      e_err = 1'b0;
      e_words = 0;
      if (n > DEPTH) begin
         e_err = 1'b1;
         return;
      end
      for (int i = 0; i < n; i++) exp_q.push_back({8'(i), s[3 + 2 * i], s[2 + 2 * i]});
      e_words = n;
      sum = 8'd0;
      foreach (s[i]) sum = sum + s[i];
`ifdef CHECKSUM_EN
      e_done = (sum == 8'd0);
      e_err = !e_done;
`else
      e_done = 1'b1;
`endif
   endtask

   // drivers
   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_stream(input bq_t s, input int gap_max, input int start_at);
      for (int i = 0; i < s.size(); i++) begin
         int gap;
         int t;
         gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
         for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            in_valid = 1'b0;
         end
         if (i == start_at) begin
            @(negedge clk);
            in_valid = 1'b0;
            start = 1'b1;
         end
         @(negedge clk);
         start = 1'b0;
         in_valid = 1'b1;
         in_data = s[i];
         t = 0;
         while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
         end
         if (t >= 100) begin
            check_val("byte_accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
         end
         @(posedge clk);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_end();
      int t;
      t = 0;
      while (!(done || error) && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) check_val("end_timeout", 32'd0, 32'd1);
      @(negedge clk);
   endtask

   task automatic run_load(input string tag, input bq_t s, input int gap_max, input int start_at);
      bit e_done, e_err;
      int e_words;
      model_load(s, e_done, e_err, e_words);
      pulse_start();
      send_stream(s, gap_max, start_at);
      wait_end();
      check_val({tag, "_done"}, {31'd0, done}, {31'd0, e_done});
      check_val({tag, "_error"}, {31'd0, error}, {31'd0, e_err});
      check_val({tag, "_cpu_rst_n"}, {31'd0, cpu_rst_n}, {31'd0, e_done});
      check_val({tag, "_words"}, 32'(words_loaded), 32'(e_words));
      check_val({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #1ms;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "global timeout");
   end

   initial begin
      bq_t s;
      bq_t img;
      rst_n = 1'b0;
      start = 1'b0;
      in_valid = 1'b0;
      in_data = 8'd0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check_val("rst_in_ready", {31'd0, in_ready}, 32'd0);
      check_val("rst_imem_we", {31'd0, imem_we}, 32'd0);
      check_val("rst_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
      check_val("rst_done", {31'd0, done}, 32'd0);
      check_val("rst_error", {31'd0, error}, 32'd0);
      check_val("rst_words", 32'(words_loaded), 32'd0);

      img = '{8'h03, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'h01, 8'h00};
      run_load("basic", finalize(img, 1'b0), 0, -1);
      run_load("empty", finalize('{8'h00, 8'h00}, 1'b0), 0, -1);
      run_load("overflow", '{8'h01, 8'h01}, 0, -1);

      s = '{8'h00, 8'h01};
      for (int i = 0; i < 2 * DEPTH; i++) s.push_back(8'($urandom));
      run_load("full", finalize(s, 1'b0), 0, -1);
      check_val("full_last_addr", 32'(imem_addr), 32'hFF);

      run_load("gaps_restart", finalize(img, 1'b0), 3, 4);

`ifdef CHECKSUM_EN
      run_load("chk_good", '{8'h01, 8'h00, 8'h34, 8'h12, 8'hB9}, 0, -1);
      run_load("chk_bad", '{8'h01, 8'h00, 8'h34, 8'h12, 8'hB8}, 1, -1);
`endif

      for (int k = 0; k < 8; k++) begin
         int n;
         n = int'($urandom_range(12, 1));
         s = '{8'(n), 8'h00};
         for (int i = 0; i < 2 * n; i++) s.push_back(8'($urandom));
         run_load("random", finalize(s, 1'($urandom_range(1, 0))), int'($urandom_range(2, 0)),
                  ($urandom_range(1, 0) == 1) ? int'($urandom_range(2 * n + 1, 2)) : -1);
      end

      // abort mid-load: only the first complete word may be written
      exp_q.push_back({8'h00, 16'h1234});
      pulse_start();
      send_stream('{8'h03, 8'h00, 8'h34, 8'h12, 8'hCD}, 0, -1);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_val("abort_in_ready", {31'd0, in_ready}, 32'd0);
      check_val("abort_imem_we", {31'd0, imem_we}, 32'd0);
      check_val("abort_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
      check_val("abort_done", {31'd0, done}, 32'd0);
      check_val("abort_error", {31'd0, error}, 32'd0);
      check_val("abort_words", 32'(words_loaded), 32'd0);
      check_val("abort_addr_data", {8'd0, imem_addr, imem_wdata}, 32'd0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check_val("abort_idle_in_ready", {31'd0, in_ready}, 32'd0);
      check_val("abort_idle_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
      check_val("abort_pending_writes", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
